// File: rtl/mmio_responder.sv
// Memory-mapped peripheral: scratch, status, TX FIFO, RX holding register, control, cycle counter, GPIO.
// Optional build macro MMIO_COUNTER_EN enables the free-running 32-bit COUNTER at offset 5.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        cs,
  input  logic        we,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready,
  output logic [7:0]  gpio_out
);

  localparam int unsigned PW      = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(TX_DEPTH);

  typedef enum logic [2:0] {
    OFF_SCRATCH = 3'd0,
    OFF_STATUS  = 3'd1,
    OFF_TX_DATA = 3'd2,
    OFF_RX_DATA = 3'd3,
    OFF_CTRL    = 3'd4,
    OFF_COUNTER = 3'd5,
    OFF_GPIO    = 3'd6,
    OFF_RSVD    = 3'd7
  } reg_off_e;

  logic            sel, wr_en, tx_wr, ctrl_wr, flush, push, pop;
  logic            tx_empty, tx_full;
  reg_off_e        off;
  logic [31:0]     rdata, counter_val, status;

  logic [31:0]     scratch_q, scratch_d;
  logic [7:0]      gpio_q, gpio_d;
  logic [31:0]     rx_data_q, rx_data_d;
  logic            rx_hold_q, rx_hold_d;
  logic            tx_ovf_q, tx_ovf_d;
  logic [4:0]      tx_count_q, tx_count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_out_q, data_out_d;
  logic [31:0]     mem [TX_DEPTH];

  assign sel     = ~cs && (addr[31:3] == BASE_ADDR[31:3]);
  assign off     = reg_off_e'(addr[2:0]);
  assign wr_en   = sel && we;
  assign tx_wr   = wr_en && (off == OFF_TX_DATA);
  assign ctrl_wr = wr_en && (off == OFF_CTRL);
  assign flush   = ctrl_wr && data_in[1];

  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == DEPTH_C);
  assign pop      = ~tx_empty && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = tx_wr && (~tx_full || pop) && ~flush;

  assign status = {23'b0, tx_ovf_q, rx_hold_q, tx_empty, tx_full, tx_count_q};

`ifdef MMIO_COUNTER_EN
  logic [31:0] counter_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) counter_q <= '0;
    else      counter_q <= counter_q + 32'd1;
  end
  assign counter_val = counter_q;
`else
  assign counter_val = '0;
`endif

  always_comb begin
    scratch_d  = scratch_q;
    gpio_d     = gpio_q;
    rx_data_d  = rx_data_q;
    rx_hold_d  = rx_hold_q;
    tx_ovf_d   = tx_ovf_q;
    tx_count_d = tx_count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rdata      = '0;

    if (wr_en && off == OFF_SCRATCH) scratch_d = data_in;
    if (wr_en && off == OFF_GPIO)    gpio_d    = data_in[7:0];

    if (flush) begin
      tx_count_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      tx_count_d = tx_count_q + 5'd1;
      else if (pop && !push) tx_count_d = tx_count_q - 5'd1;
    end

    if (ctrl_wr && data_in[2])                 tx_ovf_d = 1'b0;
    else if (tx_wr && tx_full && !pop && !flush) tx_ovf_d = 1'b1;

    // An accepted handshake wins over a same-cycle ack of an already empty holder.
    if (rx_valid && !rx_hold_q) begin
      rx_data_d = rx_data;
      rx_hold_d = 1'b1;
    end else if (ctrl_wr && data_in[0]) begin
      rx_hold_d = 1'b0;
    end

    case (off)
      OFF_SCRATCH: rdata = scratch_q;
      OFF_STATUS:  rdata = status;
      OFF_RX_DATA: rdata = rx_data_q;
      OFF_COUNTER: rdata = counter_val;
      OFF_GPIO:    rdata = {24'b0, gpio_q};
      default:     rdata = '0;
    endcase
    data_out_d = (sel && !we) ? rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch_q  <= '0;
      gpio_q     <= '0;
      rx_data_q  <= '0;
      rx_hold_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      tx_count_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      scratch_q  <= scratch_d;
      gpio_q     <= gpio_d;
      rx_data_q  <= rx_data_d;
      rx_hold_q  <= rx_hold_d;
      tx_ovf_q   <= tx_ovf_d;
      tx_count_q <= tx_count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  assign data_out = data_out_q;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : mem[rd_ptr_q];
  assign rx_ready = ~rx_hold_q;
  assign gpio_out = gpio_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder (TX_DEPTH = 8, default base address).
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        cs = 1'b1;
  logic        we = 1'b0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready;
  logic [7:0]  gpio_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mmio_responder #(.BASE_ADDR(BASE), .TX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
    .cs(cs), .we(we), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .gpio_out(gpio_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    cs = 1'b1; we = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
    addr = BASE + {29'b0, off}; cs = 1'b0; we = 1'b1; data_in = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [31:0] v);
    addr = BASE + {29'b0, off}; cs = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    v = data_out;
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, c1, c2;
    logic [31:0] exp_q [8];

    #1 rst = 1'b0;
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("rst_gpio", {24'b0, gpio_out}, 32'h0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    bus_read(3'd1, v);  check("status_after_reset", v, 32'h40);

    bus_write(3'd0, 32'hDEAD_BEEF);
    bus_read(3'd0, v);  check("scratch_rw", v, 32'hDEAD_BEEF);
    addr = BASE; cs = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    check("read_cs_high", data_out, 32'h0);
    addr = BASE + 32'd8; cs = 1'b0;
    @(posedge clk); #1;
    check("read_outside_window", data_out, 32'h0);
    bus_idle();

    bus_write(3'd6, 32'h0000_01A5);
    check("gpio_out_after_write", {24'b0, gpio_out}, 32'hA5);
    bus_read(3'd6, v);  check("gpio_read", v, 32'hA5);

    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd1, v);  check("status_after_ro_writes", v, 32'h40);
    bus_read(3'd3, v);  check("rxdata_after_ro_write", v, 32'h0);
    bus_read(3'd2, v);  check("read_txdata_zero", v, 32'h0);
    bus_read(3'd4, v);  check("read_ctrl_zero", v, 32'h0);
    bus_read(3'd7, v);  check("read_rsvd_zero", v, 32'h0);

    // Fill 8 and overflow with a 9th write
    for (int i = 0; i < 9; i++) bus_write(3'd2, 32'h100 + 32'(i));
    bus_read(3'd1, v);  check("status_full_ovf", v, 32'h128);
    check("tx_head_first", tx_data, 32'h100);
    check("tx_valid_full", {31'b0, tx_valid}, 32'h1);

    bus_write(3'd4, 32'h4);
    bus_read(3'd1, v);  check("status_ovf_cleared", v, 32'h28);

    tx_ready = 1'b1;
    bus_write(3'd2, 32'h55);
    tx_ready = 1'b0;
    bus_read(3'd1, v);  check("status_full_push_pop", v, 32'h28);
    check("tx_head_after_pop", tx_data, 32'h101);

    for (int i = 0; i < 7; i++) exp_q[i] = 32'h101 + 32'(i);
    exp_q[7] = 32'h55;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), tx_data, exp_q[i]);
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check("tx_valid_drained", {31'b0, tx_valid}, 32'h0);
    bus_read(3'd1, v);  check("status_drained", v, 32'h40);

    bus_write(3'd2, 32'hA);
    bus_write(3'd2, 32'hB);
    bus_write(3'd2, 32'hC);
    bus_read(3'd1, v);  check("status_three", v, 32'h03);
    tx_ready = 1'b1;
    bus_write(3'd4, 32'h2);
    check("tx_valid_after_flush", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    bus_read(3'd1, v);  check("status_after_flush", v, 32'h40);
    bus_write(3'd2, 32'h77);
    check("tx_head_after_flush_push", tx_data, 32'h77);
    bus_read(3'd1, v);  check("status_one_after_flush", v, 32'h01);
    bus_write(3'd4, 32'h2);

    rx_valid = 1'b1; rx_data = 32'h1234;
    @(posedge clk); #1;
    check("rx_ready_low", {31'b0, rx_ready}, 32'h0);
    rx_data = 32'h9999;
    @(posedge clk); #1;
    bus_read(3'd3, v);  check("rx_data_held", v, 32'h1234);
    bus_read(3'd1, v);  check("status_rx_hold", v, 32'hC0);
    bus_write(3'd4, 32'h1);
    check("rx_ready_after_ack", {31'b0, rx_ready}, 32'h1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    bus_read(3'd3, v);  check("rx_data_second", v, 32'h9999);
    bus_write(3'd4, 32'h1);

`ifdef MMIO_COUNTER_EN
    bus_read(3'd5, c1);
    repeat (6) @(posedge clk);
    #1;
    bus_read(3'd5, c2);
    check("counter_delta", c2 - c1, 32'd7);
`else
    c1 = '0; c2 = '0;
    bus_read(3'd5, v);  check("counter_disabled", v, 32'h0);
`endif

    bus_write(3'd6, 32'h3C);
    bus_write(3'd2, 32'h11);
    bus_write(3'd2, 32'h22);
    rx_valid = 1'b1; rx_data = 32'h42;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    addr = BASE; cs = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_read", data_out, 32'hDEAD_BEEF);
    #3 rst = 1'b0;
    #1;
    check("async_rst_data_out", data_out, 32'h0);
    check("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("async_rst_tx_data", tx_data, 32'h0);
    check("async_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    check("async_rst_gpio", {24'b0, gpio_out}, 32'h0);
    bus_idle();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    bus_read(3'd1, v);  check("status_post_reset", v, 32'h40);
    bus_read(3'd0, v);  check("scratch_post_reset", v, 32'h0);
    bus_read(3'd3, v);  check("rxdata_post_reset", v, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
